fetch_stage: RTL

Instruction-fetch stage with PC register, instruction-memory request/acknowledge handshake, and IF/ID pipeline register. It sits directly upstream of the main decoder. It presents the fetched instruction, with its 6-bit opcode field split out, to the decoder and the rest of decode. Branch/jump redirects from downstream and a decode stall are handled here, including an instruction memory with variable latency.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. It holds the PC, runs the request/acknowledge
//   handshake with a variable-latency instruction memory, and owns the IF/ID
//   pipeline register that feeds decode. It also absorbs decode stalls
//   through a one-word skid buffer, and it handles branch/jump redirects. A
//   redirect that arrives while a request is in flight lets that request
//   finish on the bus, then drops its data.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   imem_req         request outstanding (held until imem_ack)
//   imem_addr        word-aligned fetch address (= pc)
//   imem_ack         imem_rdata valid this cycle (ignored when imem_req=0)
//   imem_rdata       instruction word from memory
//   stall            decode cannot accept; IF/ID holds
//   redirect         taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc      redirect target (low two bits ignored)
//   if_valid         IF/ID holds a valid instruction
//   if_instr         IF/ID instruction
//   if_opcode        if_instr[31:26]
//   if_pc4           address of if_instr plus 4
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | one cycle after reset; no request on the bus
// REQ   | request for pc on the bus, waiting for / consuming ack
// HOLD  | fetched word parked in skid buffer while decode stalls; bus idle
// DROP  | redirected while a request was in flight; wait out its ack, then
//       | continue at tgt

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] skid_buf;

  logic [31:0] pc_inc;
  logic [31:0] rpc_al;

  // pc+4 wraps naturally at 2^32
  assign pc_inc = pc + 32'd4;
  assign rpc_al = redirect_pc & 32'hFFFF_FFFC;

  assign imem_addr = pc;
  assign imem_req  = (state == REQ) || (state == DROP);
  assign if_opcode = if_instr[31:26];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      tgt      <= 32'h0;
      skid_buf <= 32'h0;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc4   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect) begin
            pc       <= rpc_al;
            if_valid <= 1'b0;
          end
        end

        REQ: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              // acked word belongs to the squashed path; fetch target now
              pc <= rpc_al;
            end else begin
              // leave the in-flight request untouched on the bus
              tgt   <= rpc_al;
              state <= DROP;
            end
          end else if (imem_ack) begin
            if (stall) begin
              skid_buf <= imem_rdata;
              state    <= HOLD;
            end else begin
              if_instr <= imem_rdata;
              if_pc4   <= pc_inc;
              if_valid <= 1'b1;
              pc       <= pc_inc;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end

        HOLD: begin
          // pc still names the buffered word here
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= rpc_al;
            state    <= REQ;
          end else if (!stall) begin
            if_instr <= skid_buf;
            if_pc4   <= pc_inc;
            if_valid <= 1'b1;
            pc       <= pc_inc;
            state    <= REQ;
          end
        end

        DROP: begin
          if (redirect) begin
            if_valid <= 1'b0;
            tgt      <= rpc_al;
            if (imem_ack) begin
              pc    <= rpc_al;
              state <= REQ;
            end
          end else if (imem_ack) begin
            pc    <= tgt;
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
